// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_fifo
// Purpose  : Buffers per-instruction retire records for the lock-step
//            checker, stamps each accepted record with a 16-bit sequence
//            number, raises early backpressure and flags dropped retires.
// Options  : COMMIT_TRACE_BYPASS_EN - zero-latency forward of a retire to
//            the checker when the FIFO is empty and the checker is ready.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     ret_valid_i,
  input  logic [ADDR_WIDTH-1:0]    ret_pc_i,
  input  logic [INSTR_WIDTH-1:0]   ret_instr_i,
  input  logic                     ret_rd_we_i,
  input  logic [REG_AW-1:0]        ret_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]    ret_rd_data_i,
  input  logic                     ret_dmem_op_i,
  input  logic                     ret_dmem_we_i,
  input  logic [ADDR_WIDTH-1:0]    ret_dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]    ret_dmem_data_i,
  output logic                     stall_o,
  output logic                     chk_valid_o,
  input  logic                     chk_ready_i,
  output logic [ADDR_WIDTH-1:0]    chk_pc_o,
  output logic [INSTR_WIDTH-1:0]   chk_instr_o,
  output logic                     chk_rd_we_o,
  output logic [REG_AW-1:0]        chk_rd_addr_o,
  output logic [DATA_WIDTH-1:0]    chk_rd_data_o,
  output logic                     chk_dmem_op_o,
  output logic                     chk_dmem_we_o,
  output logic [ADDR_WIDTH-1:0]    chk_dmem_addr_o,
  output logic [DATA_WIDTH-1:0]    chk_dmem_data_o,
  output logic [15:0]              chk_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;
  localparam int REC_W = 2*ADDR_WIDTH + INSTR_WIDTH + 1 + REG_AW + 2*DATA_WIDTH + 2 + 16;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_C = PW'(STALL_MARGIN);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [15:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d, stall_q, stall_d;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [REC_W-1:0] in_rec, head_rec, out_rec;
  logic             empty, full, push, pop, bypass, accept, drop, chk_valid;
  logic             san_rd_we, san_dmem_we;
  logic [ADDR_WIDTH-1:0] san_dmem_addr;
  logic [DATA_WIDTH-1:0] san_dmem_data;

  // Sanitise the incoming record: no x0 writes, no dmem fields without an access.
  always_comb begin
    san_rd_we     = ret_rd_we_i & (ret_rd_addr_i != '0);
    san_dmem_we   = ret_dmem_op_i & ret_dmem_we_i;
    san_dmem_addr = ret_dmem_op_i ? ret_dmem_addr_i : '0;
    san_dmem_data = ret_dmem_op_i ? ret_dmem_data_i : '0;
    in_rec = {ret_pc_i, ret_instr_i, san_rd_we, ret_rd_addr_i, ret_rd_data_i,
              ret_dmem_op_i, san_dmem_we, san_dmem_addr, san_dmem_data, seq_q};
  end

  assign empty    = (rd_ptr_q == wr_ptr_q);
  assign full     = (rd_ptr_q[IW-1:0] == wr_ptr_q[IW-1:0]) & (rd_ptr_q[IW] != wr_ptr_q[IW]);
  assign head_rec = mem_q[rd_ptr_q[IW-1:0]];

`ifdef COMMIT_TRACE_BYPASS_EN
  assign bypass    = empty & chk_ready_i & ret_valid_i;
  assign chk_valid = ~empty | ret_valid_i;
  assign out_rec   = chk_valid ? (empty ? in_rec : head_rec) : '0;
`else
  assign bypass    = 1'b0;
  assign chk_valid = ~empty;
  assign out_rec   = chk_valid ? head_rec : '0;
`endif

  // A pop only ever drains a stored record; a bypassed retire never touches storage.
  assign pop    = ~empty & chk_ready_i;
  assign push   = ret_valid_i & (~full | pop) & ~bypass;
  assign accept = push | bypass;
  assign drop   = ret_valid_i & ~accept;

  // Next-state for pointers, occupancy, sequence counter and status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q;
    if (push & ~pop)      count_d = count_q + 1'b1;
    else if (pop & ~push) count_d = count_q - 1'b1;
    seq_d      = accept ? seq_q + 16'd1 : seq_q;
    overflow_d = overflow_q | drop;
    stall_d    = (DEPTH_C - count_d) <= MARGIN_C;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
    end
  end

  // Record storage; contents are only observable through a valid head.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[IW-1:0]] <= in_rec;
  end

  assign {chk_pc_o, chk_instr_o, chk_rd_we_o, chk_rd_addr_o, chk_rd_data_o,
          chk_dmem_op_o, chk_dmem_we_o, chk_dmem_addr_o, chk_dmem_data_o,
          chk_seq_o} = out_rec;

  assign chk_valid_o = chk_valid;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign stall_o     = stall_q;

endmodule
`default_nettype wire

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Buffers the core's per-instruction retire records and presents them one at a time to the lock-step checker.
- The checker steps the reference model once per record and compares PC, GPR writeback and data-memory access.
- Sits between the core retire port (upstream) and the model-stepping checker (downstream).
- Decouples retire bursts from checker throughput, stalls the core before overflow and stamps each record with a sequence number for mismatch reporting.

Parameters:
- ADDR_WIDTH, 32, PC and data-memory address width (matches sp_pkg).
- DATA_WIDTH, 32, GPR and memory data width.
- INSTR_WIDTH, 32, instruction word width.
- REG_AW, 5, GPR index width.
- DEPTH, 8, FIFO entries; power of two, at least 4.
- STALL_MARGIN, 2, free-entry threshold that raises stall_o; 1 to DEPTH-1.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-high
- ret_valid_i  in  1  retire event this cycle
- ret_pc_i  in  ADDR_WIDTH  PC of retired instruction
- ret_instr_i  in  INSTR_WIDTH  retired instruction word
- ret_rd_we_i  in  1  GPR write
- ret_rd_addr_i  in  REG_AW  GPR index
- ret_rd_data_i  in  DATA_WIDTH  GPR write data
- ret_dmem_op_i  in  1  data-memory access
- ret_dmem_we_i  in  1  access is a store
- ret_dmem_addr_i  in  ADDR_WIDTH  access address
- ret_dmem_data_i  in  DATA_WIDTH  store or load data
- stall_o  out  1  backpressure to core
- chk_valid_o  out  1  head record valid
- chk_ready_i  in  1  checker consumes head
- chk_pc_o, chk_instr_o, chk_rd_we_o, chk_rd_addr_o, chk_rd_data_o, chk_dmem_op_o, chk_dmem_we_o, chk_dmem_addr_o, chk_dmem_data_o  out  widths as inputs  head record fields
- chk_seq_o  out  16  head record sequence number
- count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: a retire was dropped

Behaviour:
- Reset: arst_i asynchronously clears read/write pointers, count_o, sequence counter and overflow_o.
  - chk_valid_o=0, stall_o=0; all chk_* data outputs 0.
  - Reset mid-burst discards all stored records.
- Pointers are $clog2(DEPTH)+1 bits; MSB distinguishes full from empty; index wraps DEPTH-1 -> 0.
- Push = ret_valid_i & (count_o<DEPTH | pop). Pop = chk_valid_o & chk_ready_i.
- Simultaneous push and pop when full: both occur; count unchanged.
- Simultaneous push and pop when empty: the pop is impossible (chk_valid_o=0); only the push occurs.
- Dropped retire (ret_valid_i, full, no pop): record discarded; overflow_o set next cycle and held until reset; sequence counter not advanced.
- Record sanitising on push:
  - rd_we stored as ret_rd_we_i & (ret_rd_addr_i!=0), so x0 writes are suppressed.
  - When ret_dmem_op_i=0, stored dmem_we/addr/data are forced to 0.
- Sequence counter: 16-bit, stamps the current value into the record on each accepted push, then increments; wraps 0xFFFF -> 0x0000.
- Latency: a record pushed in cycle N is visible on chk_* with chk_valid_o=1 in cycle N+1.
- chk_* are driven from the head entry; stable while chk_valid_o & !chk_ready_i.
- count_o registered: +1 push only, -1 pop only, unchanged for both or neither.
- stall_o registered: 1 when (DEPTH - next_count) <= STALL_MARGIN, else 0.
  - The core may still retire for up to STALL_MARGIN cycles after stall_o rises; no drop occurs if the core honours stall_o within that window.
- chk_ready_i while chk_valid_o=0 is ignored.

Optional Feature:
- Macro COMMIT_TRACE_BYPASS_EN.
- Defined: when the FIFO is empty and chk_ready_i=1, ret_valid_i forwards combinationally to chk_* in the same cycle (zero latency).
  - The record is not written and count_o is unchanged.
  - The sequence counter still increments.
  - chk_valid_o = !empty | ret_valid_i.
- Undefined: chk_valid_o = !empty only; minimum latency 1 cycle.

Test Plan:
- Reset, single retire pc=0x100, instr=0x00A00093, rd=1, data=0xA, chk_ready_i=1 -> next cycle chk_valid_o=1, chk_pc_o=0x100, chk_seq_o=0, chk_rd_we_o=1; then count_o=0.
- Retire with rd_we=1, rd_addr=0, data=0xDEAD; dmem_op=0, dmem_addr=0x55 -> chk_rd_we_o=0, chk_dmem_addr_o=0.
- chk_ready_i=0, 8 back-to-back retires, DEPTH=8, STALL_MARGIN=2 -> stall_o=1 after 6th push; count_o=8; 9th retire dropped, overflow_o=1 and stays 1; drain yields seq 0..7 in order.
- Full FIFO, ret_valid_i and chk_ready_i both high for 20 cycles -> count_o stays 8, no overflow, output seq strictly increasing by 1.
- Preload sequence counter to 0xFFFE via 65534 retires, then 3 more -> chk_seq_o 0xFFFE, 0xFFFF, 0x0000.
- 3 records queued, assert arst_i mid-cycle -> chk_valid_o, count_o, overflow_o and stall_o 0 immediately; next retire gets seq 0.
